tty_console: RTL and testbench



---
 rtl/tty_console_if.sv | 25 ++
 rtl/tty_console.sv | 195 +++++++++++++++++++
 tb/tb_tty_console.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tty_console_if.sv
// Byte-stream handshake, video-memory write port and cursor/scroll status of tty_console.
interface tty_console_if #(
    parameter int unsigned COL_W = 5,
    parameter int unsigned ROW_W = 5
);
    logic                   tty_valid;
    logic [7:0]             tty_data;
    logic                   tty_ready;
    logic                   vm_we;
    logic [ROW_W+COL_W-1:0] vm_addr;
    logic [7:0]             vm_din;
    logic [ROW_W-1:0]       scroll_top;
    logic [ROW_W-1:0]       cur_row;
    logic [COL_W-1:0]       cur_col;

    modport master (
        output tty_valid, tty_data,
        input  tty_ready, vm_we, vm_addr, vm_din, scroll_top, cur_row, cur_col
    );

    modport slave (
        input  tty_valid, tty_data,
        output tty_ready, vm_we, vm_addr, vm_din, scroll_top, cur_row, cur_col
    );
endinterface

// File: rtl/tty_console.sv
// Text-terminal write engine: turns a byte stream into character-RAM writes with cursor, wrap and
// circular-offset scrolling. Define TTY_BACKSPACE_EN to give 8'h08 destructive-backspace meaning.
module tty_console #(
    parameter int unsigned COLS  = 32,
    parameter int unsigned ROWS  = 30,
    parameter int unsigned COL_W = 5,
    parameter int unsigned ROW_W = 5,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic         clk_25mhz,
    input  logic         rst,
    tty_console_if.slave bus
);
    localparam int unsigned ADDR_W = ROW_W + COL_W;
    localparam int unsigned SUM_W  = ROW_W + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [SUM_W-1:0] ROWS_EXT = SUM_W'(ROWS);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
`ifdef TTY_BACKSPACE_EN
    localparam logic [7:0] CH_BS = 8'h08;
`endif

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_CLEAR
    } state_e;

    state_e              state_q,   state_d;
    logic                ready_q,   ready_d;
    logic                we_q,      we_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [7:0]          din_q,     din_d;
    logic [ROW_W-1:0]    top_q,     top_d;
    logic [ROW_W-1:0]    row_q,     row_d;
    logic [COL_W-1:0]    col_q,     col_d;
    logic [ROW_W-1:0]    clr_row_q, clr_row_d;
    logic [COL_W-1:0]    clr_col_q, clr_col_d;

    logic                accept;
    logic                newline;
    logic                scroll;
    logic                char_wr;
    logic [SUM_W-1:0]    phys_sum;
    logic [ROW_W-1:0]    phys_row;
    logic [ROW_W-1:0]    top_inc;

    assign accept = bus.tty_valid && ready_q;

    // Cursor's physical row: modular add by compare/subtract so non-power-of-two ROWS wraps cleanly.
    assign phys_sum = SUM_W'(top_q) + SUM_W'(row_q);
    assign phys_row = (phys_sum >= ROWS_EXT) ? ROW_W'(phys_sum - ROWS_EXT) : ROW_W'(phys_sum);
    assign top_inc  = (top_q == ROW_LAST) ? '0 : top_q + ROW_W'(1);

`ifdef TTY_BACKSPACE_EN
    logic [COL_W-1:0] bs_col;
    assign bs_col = col_q - COL_W'(1);
`endif

    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        top_d     = top_q;
        row_d     = row_q;
        col_d     = col_q;
        clr_row_d = clr_row_q;
        clr_col_d = clr_col_q;
        newline   = 1'b0;
        scroll    = 1'b0;
        char_wr   = 1'b0;

        case (state_q)
            // INIT sweeps all rows row-major; CLEAR sweeps the single row held in clr_row_q.
            S_INIT, S_CLEAR: begin
                we_d   = 1'b1;
                addr_d = {clr_row_q, clr_col_q};
                din_d  = BLANK;
                if (clr_col_q == COL_LAST) begin
                    clr_col_d = '0;
                    if (state_q == S_CLEAR || clr_row_q == ROW_LAST) begin
                        clr_row_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        clr_row_d = clr_row_q + ROW_W'(1);
                    end
                end else begin
                    clr_col_d = clr_col_q + COL_W'(1);
                end
            end

            S_IDLE: begin
                if (accept) begin
                    case (bus.tty_data)
                        CH_CR: col_d = '0;
                        CH_LF: begin
                            col_d   = '0;
                            newline = 1'b1;
                        end
`ifdef TTY_BACKSPACE_EN
                        CH_BS: begin
                            if (col_q != '0) begin
                                col_d  = bs_col;
                                we_d   = 1'b1;
                                addr_d = {phys_row, bs_col};
                                din_d  = BLANK;
                            end
                        end
`endif
                        default: begin
                            char_wr = 1'b1;
                            we_d    = 1'b1;
                            addr_d  = {phys_row, col_q};
                            din_d   = bus.tty_data;
                            if (col_q == COL_LAST) begin
                                col_d   = '0;
                                newline = 1'b1;
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end
                    endcase

                    // Bottom-row newline: old top row becomes the new bottom row and is blanked.
                    if (newline) begin
                        if (row_q != ROW_LAST) begin
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            scroll    = 1'b1;
                            top_d     = top_inc;
                            clr_row_d = top_q;
                            clr_col_d = '0;
                            state_d   = S_CLEAR;
                            if (!char_wr) begin
                                we_d   = 1'b1;
                                addr_d = {top_q, COL_W'(0)};
                                din_d  = BLANK;
                                if (COL_LAST == '0) begin
                                    state_d = S_IDLE;
                                end else begin
                                    clr_col_d = COL_W'(1);
                                end
                            end
                        end
                    end
                end
            end

            default: state_d = S_INIT;
        endcase

        // Ready only after a full cycle back in IDLE, so it trails the last sweep write by one.
        ready_d = (state_d == S_IDLE) && (state_q == S_IDLE) && !scroll;
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state_q   <= S_INIT;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= BLANK;
            top_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            clr_row_q <= '0;
            clr_col_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            top_q     <= top_d;
            row_q     <= row_d;
            col_q     <= col_d;
            clr_row_q <= clr_row_d;
            clr_col_q <= clr_col_d;
        end
    end

    assign bus.tty_ready  = ready_q;
    assign bus.vm_we      = we_q;
    assign bus.vm_addr    = addr_q;
    assign bus.vm_din     = din_q;
    assign bus.scroll_top = top_q;
    assign bus.cur_row    = row_q;
    assign bus.cur_col    = col_q;
endmodule

// File: tb/tb_tty_console.sv
// Scoreboard bench for tty_console: a screen-level model queues expected writes, a monitor checks them.
module tb_tty_console;
    localparam int COLS  = 32;
    localparam int ROWS  = 30;
    localparam int COL_W = 5;
    localparam int ROW_W = 5;
    localparam logic [7:0] BLANK = 8'h20;
`ifdef TTY_BACKSPACE_EN
    localparam bit BS_EN = 1'b1;
`else
    localparam bit BS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [ROW_W+COL_W-1:0] addr;
        logic [7:0]             data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    tty_console_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

    tty_console #(
        .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .BLANK(BLANK)
    ) dut (
        .clk_25mhz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    int  checks   = 0;
    int  failures = 0;
    int  wr_count = 0;
    wr_t sb[$];
    int  m_row, m_col, m_top;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int r, input int c, input logic [7:0] d);
        wr_t e;
        e.addr = (ROW_W+COL_W)'(r * (2 ** COL_W) + c);
        e.data = d;
        sb.push_back(e);
    endtask

    // Screen-level model: returns writes produced and expected ready-low stretch.
    task automatic model_byte(input logic [7:0] b, output int nwr, output int stall);
        int  phys;
        bit  nl;
        nwr   = 0;
        stall = 0;
        nl    = 1'b0;
        phys  = (m_top + m_row) % ROWS;
        if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_col = 0;
            nl    = 1'b1;
        end else if (b == 8'h08 && BS_EN) begin
            if (m_col > 0) begin
                m_col--;
                push(phys, m_col, BLANK);
                nwr++;
            end
        end else begin
            push(phys, m_col, b);
            nwr++;
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                nl    = 1'b1;
            end
        end
        if (nl) begin
            if (m_row < ROWS - 1) begin
                m_row++;
            end else begin
                for (int c = 0; c < COLS; c++) push(m_top, c, BLANK);
                stall = COLS + nwr;
                nwr  += COLS;
                m_top = (m_top + 1) % ROWS;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.vm_we === 1'b1) begin
            wr_t e;
            wr_count++;
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(bus.vm_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("vm_write", {bus.vm_addr, bus.vm_din}, {e.addr, e.data});
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit keep);
        int nwr, stall, n;
        model_byte(b, nwr, stall);
        bus.tty_valid = 1'b1;
        bus.tty_data  = b;
        n = 0;
        while (bus.tty_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait_bound", 32'(n < 200), 32'd1);
        if (n < 200) begin
            @(posedge clk);
            @(negedge clk);
            check("write_at_n_plus_1", 32'(bus.vm_we), 32'(nwr > 0));
            check("cur_row", 32'(bus.cur_row), 32'(m_row));
            check("cur_col", 32'(bus.cur_col), 32'(m_col));
            check("scroll_top", 32'(bus.scroll_top), 32'(m_top));
            if (stall > 0) begin
                n = 0;
                while (bus.tty_ready !== 1'b1 && n < 200) begin
                    n++;
                    @(negedge clk);
                end
                check("ready_low_cycles", 32'(n), 32'(stall));
            end else begin
                check("ready_kept_high", 32'(bus.tty_ready), 32'd1);
            end
        end
        if (!keep || n >= 200) begin
            bus.tty_valid = 1'b0;
            bus.tty_data  = 8'($urandom);
        end
    endtask

    task automatic reset_and_init();
        int n;
        rst           = 1'b1;
        bus.tty_valid = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        m_row = 0;
        m_col = 0;
        m_top = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.tty_ready), 32'd0);
        check("rst_we", 32'(bus.vm_we), 32'd0);
        check("rst_addr", 32'(bus.vm_addr), 32'd0);
        check("rst_din", 32'(bus.vm_din), 32'(BLANK));
        check("rst_scroll_top", 32'(bus.scroll_top), 32'd0);
        check("rst_cur", {bus.cur_row, bus.cur_col}, 32'd0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) push(r, c, BLANK);
        wr_count = 0;
        rst      = 1'b0;
        n        = 0;
        while (bus.tty_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("init_ready_cycle", 32'(n), 32'(ROWS * COLS + 1));
        check("init_write_count", 32'(wr_count), 32'(ROWS * COLS));
        check("init_sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #8_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr, stall, n, r;
        logic [7:0] b;
        bus.tty_valid = 1'b0;
        bus.tty_data  = 8'h00;
        reset_and_init();

        send(8'h41, 1'b1);
        send(8'h42, 1'b0);
        send(8'h0D, 1'b0);
        repeat (5) send(8'h0A, 1'b0);
        for (int i = 0; i < COLS; i++) send(8'h41, i != COLS - 1);
        send(8'h0D, 1'b0);
        while (m_row < ROWS - 1) send(8'h0A, 1'b0);
        send(8'h0A, 1'b0);
        send(8'h41, 1'b0);

        send(8'h0D, 1'b0);
        send(8'h41, 1'b1);
        send(8'h42, 1'b1);
        send(8'h43, 1'b1);
        send(8'h44, 1'b1);
        send(8'h08, 1'b0);
        send(8'h0D, 1'b0);
        send(8'h08, 1'b0);

        repeat (400) begin
            r = int'($urandom_range(0, 99));
            if (r < 8)       b = 8'h0D;
            else if (r < 20) b = 8'h0A;
            else if (r < 28) b = 8'h08;
            else             b = 8'($urandom_range(33, 126));
            send(b, $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.tty_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        bus.tty_valid = 1'b0;
        @(negedge clk);

        // Abort a scroll clear on its 10th write.
        while (m_row < ROWS - 1) send(8'h0A, 1'b0);
        model_byte(8'h0A, nwr, stall);
        bus.tty_valid = 1'b1;
        bus.tty_data  = 8'h0A;
        n = 0;
        while (bus.tty_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_accept_bound", 32'(n < 200), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.tty_valid = 1'b0;
        check("abort_first_clear", 32'(bus.vm_we), 32'd1);
        check("abort_scroll_top", 32'(bus.scroll_top), 32'(m_top));
        repeat (9) @(negedge clk);
        #1;
        reset_and_init();

        send(8'h5A, 1'b0);
        repeat (4) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
